// File: rtl/data_memory_ctl_pkg.sv
// Shared definitions for the MIPS-lite data memory: access sizes, FSM states
// and the alignment helpers used by the lane aligner.
package data_memory_ctl_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;  // 2'b11 is also treated as a word

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // True when the low address bits do not match the natural alignment of size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    if (sz == SIZE_B) return 1'b0;
    else if (sz == SIZE_H) return off[0];
    else return (off != 2'b00);
  endfunction

  // Byte offset with the bits that the access size cannot address forced to 0.
  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
    if (sz == SIZE_B) return off;
    else if (sz == SIZE_H) return {off[1], 1'b0};
    else return 2'b00;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Store side: byte enables and lane-replicated write word.
// Load side: lane extraction with sign/zero extension, plus the alignment flag.
// Build option: DMEM_MISALIGN_TRAP_EN (undefined by default) turns misaligned
// accesses into faults instead of silently aligning them.
module dmem_lane_align
  import data_memory_ctl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_wword,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data,
  output logic        misalign
);

  logic [1:0]  st_o;
  logic [1:0]  ld_o;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store path: pick lanes and replicate the right-aligned store data into them.
  always_comb begin
    st_o     = align_off(st_size, st_off);
    st_be    = 4'b0000;
    st_wword = wdata;
    if (st_size == SIZE_B) begin
      st_be    = 4'b0001 << st_o;
      st_wword = {4{wdata[7:0]}};
    end else if (st_size == SIZE_H) begin
      st_be    = 4'b0011 << st_o;
      st_wword = {2{wdata[15:0]}};
    end else begin
      st_be    = 4'b1111;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if (is_misaligned(st_size, st_off)) st_be = 4'b0000;
`endif
  end

  // Load path: extract the addressed lane and extend it to 32 bits.
  always_comb begin
    ld_o = align_off(ld_size, ld_off);
    case (ld_o)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_o[1] ? ld_raw[31:16] : ld_raw[15:0];
    if (ld_size == SIZE_B)
      ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
    else if (ld_size == SIZE_H)
      ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
    else
      ld_data = ld_raw;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = is_misaligned(ld_size, ld_off);
    if (misalign) ld_data = 32'h0;
`else
    misalign = 1'b0;
`endif
  end

endmodule

// File: rtl/data_memory_ctl.sv
// MEM-stage data memory with byte/half/word access, programmable wait states
// and a req/ready handshake. Build option: DMEM_MISALIGN_TRAP_EN (see
// dmem_lane_align) selects trapping vs. silent alignment of misaligned accesses.
module data_memory_ctl
  import data_memory_ctl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  unsigned_ld,
  input  logic [ADDR_WIDTH+1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic                  misalign
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam int unsigned BAW      = ADDR_WIDTH + 2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             cap_we;
  logic [1:0]       cap_size;
  logic             cap_uns;
  logic [BAW-1:0]   cap_addr;
  logic [31:0]      cap_wdata;

  logic [31:0]      mem [DEPTH];

  logic             accept_c;
  logic             enter_done_c;
  logic             eff_we_c;
  logic [1:0]       eff_size_c;
  logic             eff_uns_c;
  logic [BAW-1:0]   eff_addr_c;
  logic [ADDR_WIDTH-1:0] rd_word_c;
  logic [ADDR_WIDTH-1:0] st_word_c;
  logic [31:0]      rd_raw_c;
  logic [3:0]       st_be_c;
  logic [31:0]      st_wword_c;
  logic [31:0]      ld_data_c;
  logic             mis_c;

  assign accept_c     = req && ((state == ST_IDLE) || (state == ST_DONE));
  assign enter_done_c = (accept_c && (WAIT_CYCLES == 0)) || ((state == ST_BUSY) && (cnt == 4'd0));
  assign st_word_c    = cap_addr[BAW-1:2];
  assign rd_word_c    = eff_addr_c[BAW-1:2];

  // Request that is about to complete: captured fields while waiting, live inputs on a zero-wait accept.
  always_comb begin
    if (state == ST_BUSY) begin
      eff_we_c   = cap_we;
      eff_size_c = cap_size;
      eff_uns_c  = cap_uns;
      eff_addr_c = cap_addr;
    end else begin
      eff_we_c   = we;
      eff_size_c = size;
      eff_uns_c  = unsigned_ld;
      eff_addr_c = addr;
    end
  end

  // Array read with forwarding of a store committing on the same edge.
  always_comb begin
    rd_raw_c = mem[rd_word_c];
    if ((state == ST_DONE) && cap_we && (rd_word_c == st_word_c)) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be_c[b]) rd_raw_c[8*b +: 8] = st_wword_c[8*b +: 8];
      end
    end
  end

  dmem_lane_align u_align (
    .st_size     (cap_size),
    .st_off      (cap_addr[1:0]),
    .wdata       (cap_wdata),
    .st_be       (st_be_c),
    .st_wword    (st_wword_c),
    .ld_size     (eff_size_c),
    .ld_off      (eff_addr_c[1:0]),
    .ld_unsigned (eff_uns_c),
    .ld_raw      (rd_raw_c),
    .ld_data     (ld_data_c),
    .misalign    (mis_c)
  );

  // Handshake FSM, wait counter, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      rdata     <= 32'h0;
      misalign  <= 1'b0;
      cap_we    <= 1'b0;
      cap_size  <= SIZE_W;
      cap_uns   <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= 32'h0;
    end else begin
      ready    <= enter_done_c;
      misalign <= enter_done_c && mis_c;
      if (enter_done_c && !eff_we_c) rdata <= ld_data_c;
      if (accept_c) begin
        cap_we    <= we;
        cap_size  <= size;
        cap_uns   <= unsigned_ld;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept_c) begin
            if (WAIT_CYCLES == 0) begin
              state <= ST_DONE;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_LOAD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt == 4'd0) state <= ST_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Store commit on the edge leaving DONE; a reset in that cycle drops it.
  always_ff @(posedge clk) begin
    if (rst_n && (state == ST_DONE) && cap_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be_c[b]) mem[st_word_c][8*b +: 8] <= st_wword_c[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctl.sv
// Testbench for data_memory_ctl: directed vector table, hand-written handshake
// sequences and a randomized run against a byte-array reference model.
module tb_data_memory_ctl;

  localparam int unsigned AW   = 6;
  localparam int unsigned WAIT = 3;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          unsigned_ld;
  logic [AW+1:0] addr;
  logic [31:0]   wdata;
  logic          ready;
  logic [31:0]   rdata;
  logic          misalign;

  int n_checks = 0;
  int n_errors = 0;

  data_memory_ctl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rdata       (rdata),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic        u;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        mi;
  } vec_t;

  vec_t        tbl [22];
  logic [7:0]  mref [256];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access starting in IDLE/DONE; returns the result and edges from accept to ready.
  task automatic access(input logic w, input logic [1:0] s, input logic u, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic mi,
                        output int lat);
    req = 1'b1; we = w; size = s; unsigned_ld = u; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); unsigned_ld = 1'($urandom);
    addr = 8'($urandom); wdata = $urandom;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rdata;
    mi = misalign;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_rd;
    logic [31:0] val;
    logic        mi;
    logic        exp_mi;
    logic        saw;
    int          lat;
    int          nb;
    int          base;

    // Reset held with a request pending.
    rst_n = 1'b0; req = 1'b1; we = 1'b1; size = 2'd2; unsigned_ld = 1'b0;
    addr = 8'h3C; wdata = 32'h0;
    repeat (4) begin
      @(posedge clk); #1;
      check("reset ready", 32'(ready), 32'd0);
      check("reset rdata", rdata, 32'h0);
      check("reset misalign", 32'(misalign), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("first ready latency", 32'(lat), 32'(WAIT));
    check("first store rdata held", rdata, 32'h0);

    // Directed vectors.
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 8'h10, 32'h0, 32'hFFFFFFEF, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 8'h11, 32'h0, 32'hFFFFFFBE, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 8'h12, 32'h0, 32'hFFFFFFAD, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h13, 32'h0, 32'hFFFFFFDE, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b1, 8'h13, 32'h0, 32'h000000DE, 1'b0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 8'h20, 32'h0, 32'h000000DE, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 8'h22, 32'h12348001, 32'h000000DE, 1'b0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 32'h80010000, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 8'h22, 32'h0, 32'hFFFF8001, 1'b0};
    tbl[10] = '{1'b0, 2'd1, 1'b1, 8'h22, 32'h0, 32'h00008001, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 8'h21, 32'hABCDEF7F, 32'h00008001, 1'b0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 32'h80017F00, 1'b0};
    tbl[13] = '{1'b0, 2'd3, 1'b1, 8'h20, 32'h0, 32'h80017F00, 1'b0};
    tbl[14] = '{1'b0, 2'd1, 1'b0, 8'h20, 32'h0, 32'h00007F00, 1'b0};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 8'h04, 32'h11223344, 32'h00007F00, 1'b0};
    tbl[16] = '{1'b0, 2'd2, 1'b0, 8'h06, 32'h0, TRAP ? 32'h0 : 32'h11223344, TRAP};
    tbl[17] = '{1'b1, 2'd2, 1'b0, 8'h06, 32'hAAAAAAAA, TRAP ? 32'h0 : 32'h11223344, TRAP};
    tbl[18] = '{1'b0, 2'd2, 1'b0, 8'h04, 32'h0, TRAP ? 32'h11223344 : 32'hAAAAAAAA, 1'b0};
    tbl[19] = '{1'b0, 2'd1, 1'b0, 8'h23, 32'h0, TRAP ? 32'h0 : 32'hFFFF8001, TRAP};
    tbl[20] = '{1'b0, 2'd0, 1'b1, 8'h23, 32'h0, 32'h00000080, 1'b0};
    tbl[21] = '{1'b0, 2'd0, 1'b0, 8'h22, 32'h0, 32'h00000001, 1'b0};
    for (int i = 0; i < 22; i++) begin
      access(tbl[i].w, tbl[i].s, tbl[i].u, tbl[i].a, tbl[i].d, rd, mi, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(WAIT));
      check($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d misalign", i), 32'(mi), 32'(tbl[i].mi));
      if (i % 3 == 0) begin
        @(posedge clk); #1;
      end
    end

    // Back-to-back store then load with req held high.
    req = 1'b1; we = 1'b1; size = 2'd2; unsigned_ld = 1'b0; addr = 8'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b store latency", 32'(lat), 32'(WAIT));
    we = 1'b0; wdata = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 40);
    check("b2b ready spacing", 32'(lat), 32'(WAIT + 1));
    check("b2b load rdata", rdata, 32'hCAFEF00D);
    req = 1'b0;
    @(posedge clk); #1;
    check("ready single pulse", 32'(ready), 32'd0);

    // Reset during a store's wait cycles.
    req = 1'b1; we = 1'b1; size = 2'd2; addr = 8'h30; wdata = 32'h55555555;
    @(posedge clk); #1;
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset rdata cleared", rdata, 32'h0);
    saw = ready;
    repeat (6) begin
      @(posedge clk); #1;
      saw = saw | ready;
    end
    check("midreset no ready", 32'(saw), 32'd0);
    access(1'b0, 2'd2, 1'b0, 8'h30, 32'h0, rd, mi, lat);
    check("midreset old data", rd, 32'hCAFEF00D);
    exp_rd = rd;

    // Randomized accesses against the byte-array model.
    for (int w = 0; w < 64; w++) begin
      val = $urandom;
      access(1'b1, 2'd2, 1'b0, 8'(w * 4), val, rd, mi, lat);
      for (int i = 0; i < 4; i++) mref[w * 4 + i] = val[8*i +: 8];
      if (lat != WAIT) check("init latency", 32'(lat), 32'(WAIT));
    end
    for (int t = 0; t < 300; t++) begin
      logic        rw;
      logic [1:0]  rs;
      logic        ru;
      logic [7:0]  ra;
      logic [31:0] rdv;
      rw = 1'($urandom); rs = 2'($urandom); ru = 1'($urandom);
      ra = 8'($urandom); rdv = $urandom;
      nb = (rs == 2'd0) ? 1 : (rs == 2'd1) ? 2 : 4;
      base = int'(ra) - (int'(ra) % nb);
      exp_mi = 1'b0;
      if (TRAP && (int'(ra) % nb != 0)) begin
        exp_mi = 1'b1;
        if (!rw) exp_rd = 32'h0;
      end else if (rw) begin
        for (int i = 0; i < nb; i++) mref[base + i] = rdv[8*i +: 8];
      end else begin
        val = 32'h0;
        for (int i = 0; i < nb; i++) val = val | (32'(mref[base + i]) << (8 * i));
        if (!ru && nb < 4 && val[8*nb-1]) val = val | (32'hFFFFFFFF << (8 * nb));
        exp_rd = val;
      end
      access(rw, rs, ru, ra, rdv, rd, mi, lat);
      check($sformatf("rand%0d latency", t), 32'(lat), 32'(WAIT));
      check($sformatf("rand%0d rdata", t), rd, exp_rd);
      check($sformatf("rand%0d misalign", t), 32'(mi), 32'(exp_mi));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
